hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Parametrised pipeline hazard controller for the 5-stage MIPS core, the successor to the flush-only hazard detector. It adds load-use stall detection, a multi-cycle mul/div stall sequencer and a saturating stall-cycle performance counter. It also supports a selectable branch-resolution stage. It sits beside the ID stage and drives the PC and IF/ID, ID/EX, EX/MEM pipeline-register write-enables and flushes.

## Interface
Parameters:
- REG_ADDR_W, 5, register-specifier width
- MD_LATENCY, 4, cycles a mul/div occupies EX; legal range 2..16
- BRANCH_IN_EX, 1, 1: branch resolved in EX; 0: resolved in MEM (EX/MEM also flushed)
- CNT_W, 16, stall-counter width

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- jump  in  1  jump decoded in ID
- pc_src  in  1  branch taken, from the resolving stage
- id_rs, id_rt  in  REG_ADDR_W  source specifiers of the instruction in ID
- id_uses_rt  in  1  instruction in ID reads rt
- ex_mem_read  in  1  instruction in EX is a load
- ex_rt  in  REG_ADDR_W  load destination in EX
- md_start  in  1  mul/div instruction present in EX
- cnt_clr  in  1  synchronous clear of stall_cycles
- pc_write, if_id_write, id_ex_write  out  1  register enables (1 = update)
- if_id_flush, id_ex_flush, ex_mem_flush  out  1  insert bubble
- md_busy  out  1  sequencer in BUSY state
- stall_cycles  out  CNT_W  count of cycles with pc_write=0

## Operation
- Outputs are combinational from inputs and registered state. Default: all writes 1, all flushes 0.
- Event priority, highest first: rst, pc_src, MD stall, load-use, jump. Only the highest active event drives the outputs.
- rst: writes 1, flushes 0, md_busy 0. state<=IDLE, rem<=0, stall_cycles<=0.
- pc_src: if_id_flush=1, id_ex_flush=1, ex_mem_flush=BRANCH_IN_EX?0:1.
  - Aborts a BUSY sequence: state<=IDLE, rem<=0.
  - md_start in the same cycle is ignored.
- MD stall is active when state==IDLE with md_start=1, or when state==BUSY.
  - Outputs: pc_write=0, if_id_write=0, id_ex_write=0, ex_mem_flush=1.
- Load-use: ex_mem_read and ex_rt!=0, and either ex_rt==id_rs, or id_uses_rt with ex_rt==id_rt.
  - Outputs: pc_write=0, if_id_write=0, id_ex_flush=1.
- jump: if_id_flush=1.
- A jump masked by a stall is not lost. ID is held, so it is re-evaluated on the next cycle.
- State machine (rem is a 4-bit down-counter):
  - IDLE, md_start, no pc_src: stall this cycle; rem<=MD_LATENCY-2. Go BUSY if MD_LATENCY>2, else stay IDLE.
  - BUSY: stall; rem<=rem-1. Go IDLE when rem==1.
  - md_start is ignored in BUSY, because it stays high while EX is held.
- Total MD stall cycles = MD_LATENCY-1. The mul/div then advances from EX on the following edge.
- stall_cycles:
  - When not in rst: cnt_clr clears it, with priority over increment.
  - Otherwise it increments each cycle pc_write==0.
  - It saturates at all-ones and never wraps.

## Timing
- Zero-cycle latency from inputs to outputs; no output registers.
- After reset deasserts, the first cycle is IDLE with default outputs unless inputs request otherwise.
- md_busy rises the cycle after the md_start cycle (only if MD_LATENCY>2). It falls the cycle after rem==1.
- Reset mid-BUSY: the next cycle is IDLE, no stall, and the counter is 0.
- Load-use during BUSY is masked. It is re-detected after return to IDLE if still present.
- Load-use yields exactly one stall cycle: the next cycle the load is in MEM and the condition clears.

## Test plan
- Load-use: ex_mem_read=1, ex_rt=8, id_rs=8, one cycle -> pc_write=0, if_id_write=0, id_ex_flush=1. Repeat with ex_rt=0 -> no stall.
- MD_LATENCY=4, md_start held 3 cycles -> stall in cycles 0,1,2; md_busy high in cycles 1,2; cycle 3 defaults; stall_cycles=3.
- BUSY with rem=1, pc_src=1 -> if_id_flush=id_ex_flush=1, stall released; next cycle IDLE, md_busy=0.
- jump and load-use together -> stall only, no if_id_flush. Next cycle, jump alone -> if_id_flush=1.
- BRANCH_IN_EX=0, pc_src=1 -> all three flushes 1. BRANCH_IN_EX=1 -> ex_mem_flush=0.
- CNT_W=4, 20 load-use stalls -> stall_cycles=15. cnt_clr -> 0. rst mid-BUSY -> IDLE, counter 0.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: branch/jump flushes, load-use stall, multi-cycle
// mul/div stall sequencer and a saturating stall-cycle counter.
//
// state | meaning
// IDLE  | no mul/div in progress; md_start begins a sequence
// BUSY  | mul/div occupying EX, rem cycles of stall left before release
module hazard_ctrl #(
    parameter int REG_ADDR_W   = 5,
    parameter int MD_LATENCY   = 4,
    parameter bit BRANCH_IN_EX = 1,
    parameter int CNT_W        = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  jump,
    input  logic                  pc_src,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_uses_rt,
    input  logic                  ex_mem_read,
    input  logic [REG_ADDR_W-1:0] ex_rt,
    input  logic                  md_start,
    input  logic                  cnt_clr,
    output logic                  pc_write,
    output logic                  if_id_write,
    output logic                  id_ex_write,
    output logic                  if_id_flush,
    output logic                  id_ex_flush,
    output logic                  ex_mem_flush,
    output logic                  md_busy,
    output logic [CNT_W-1:0]      stall_cycles
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic [3:0]       REM_INIT = 4'(MD_LATENCY - 2);
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    state_t     state;
    state_t     state_nxt;
    logic [3:0] rem;
    logic [3:0] rem_nxt;
    logic       load_use;
    logic       md_stall;

    always_comb begin
        load_use = ex_mem_read && (ex_rt != '0) &&
                   ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
        md_stall = ((state == IDLE) && md_start) || (state == BUSY);
    end

    // Only the highest-priority active event shapes the outputs.
    always_comb begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        id_ex_write  = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        if (rst) begin
            pc_write = 1'b1;
        end else if (pc_src) begin
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = !BRANCH_IN_EX;
        end else if (md_stall) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_write  = 1'b0;
            ex_mem_flush = 1'b1;
        end else if (load_use) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            id_ex_flush = 1'b1;
        end else if (jump) begin
            if_id_flush = 1'b1;
        end
        md_busy = !rst && (state == BUSY);
    end

    // md_start stays high while EX is held, so BUSY ignores it.
    always_comb begin
        state_nxt = state;
        rem_nxt   = rem;
        if (pc_src) begin
            state_nxt = IDLE;
            rem_nxt   = 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (md_start) begin
                        rem_nxt   = REM_INIT;
                        state_nxt = (MD_LATENCY > 2) ? BUSY : IDLE;
                    end
                end
                BUSY: begin
                    rem_nxt = rem - 4'd1;
                    if (rem == 4'd1) begin
                        state_nxt = IDLE;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    rem_nxt   = 4'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            rem          <= 4'd0;
            stall_cycles <= '0;
        end else begin
            state <= state_nxt;
            rem   <= rem_nxt;
            if (cnt_clr) begin
                stall_cycles <= '0;
            end else if (!pc_write && (stall_cycles != CNT_MAX)) begin
                stall_cycles <= stall_cycles + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl across several parameter sets.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       jump;
    logic       pc_src;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       id_uses_rt;
    logic       ex_mem_read;
    logic [4:0] ex_rt;
    logic       md_start;
    logic       cnt_clr;

    // a: defaults (lat 4, branch in EX); b: branch in MEM; c: 4-bit counter; d: lat 2
    logic        pw_a, ifw_a, idw_a, iff_a, idf_a, emf_a, busy_a;
    logic        pw_b, ifw_b, idw_b, iff_b, idf_b, emf_b, busy_b;
    logic        pw_c, ifw_c, idw_c, iff_c, idf_c, emf_c, busy_c;
    logic        pw_d, ifw_d, idw_d, iff_d, idf_d, emf_d, busy_d;
    logic [15:0] cnt_a, cnt_b, cnt_d;
    logic [3:0]  cnt_c;

    logic [6:0] ctl_a, ctl_b, ctl_d;
    assign ctl_a = {pw_a, ifw_a, idw_a, iff_a, idf_a, emf_a, busy_a};
    assign ctl_b = {pw_b, ifw_b, idw_b, iff_b, idf_b, emf_b, busy_b};
    assign ctl_d = {pw_d, ifw_d, idw_d, iff_d, idf_d, emf_d, busy_d};

    // {pc_write, if_id_write, id_ex_write, if_id_flush, id_ex_flush, ex_mem_flush, md_busy}
    localparam logic [6:0] C_DEF    = 7'b1110000;
    localparam logic [6:0] C_LU     = 7'b0010100;
    localparam logic [6:0] C_MD     = 7'b0000010;
    localparam logic [6:0] C_MDB    = 7'b0000011;
    localparam logic [6:0] C_BR_EX  = 7'b1111100;
    localparam logic [6:0] C_BR_MEM = 7'b1111110;
    localparam logic [6:0] C_JMP    = 7'b1111000;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.REG_ADDR_W(5), .MD_LATENCY(4), .BRANCH_IN_EX(1), .CNT_W(16)) dut_a (
        .clk(clk), .rst(rst), .jump(jump), .pc_src(pc_src), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rt(id_uses_rt), .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .md_start(md_start),
        .cnt_clr(cnt_clr), .pc_write(pw_a), .if_id_write(ifw_a), .id_ex_write(idw_a),
        .if_id_flush(iff_a), .id_ex_flush(idf_a), .ex_mem_flush(emf_a), .md_busy(busy_a),
        .stall_cycles(cnt_a));

    hazard_ctrl #(.REG_ADDR_W(5), .MD_LATENCY(4), .BRANCH_IN_EX(0), .CNT_W(16)) dut_b (
        .clk(clk), .rst(rst), .jump(jump), .pc_src(pc_src), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rt(id_uses_rt), .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .md_start(md_start),
        .cnt_clr(cnt_clr), .pc_write(pw_b), .if_id_write(ifw_b), .id_ex_write(idw_b),
        .if_id_flush(iff_b), .id_ex_flush(idf_b), .ex_mem_flush(emf_b), .md_busy(busy_b),
        .stall_cycles(cnt_b));

    hazard_ctrl #(.REG_ADDR_W(5), .MD_LATENCY(4), .BRANCH_IN_EX(1), .CNT_W(4)) dut_c (
        .clk(clk), .rst(rst), .jump(jump), .pc_src(pc_src), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rt(id_uses_rt), .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .md_start(md_start),
        .cnt_clr(cnt_clr), .pc_write(pw_c), .if_id_write(ifw_c), .id_ex_write(idw_c),
        .if_id_flush(iff_c), .id_ex_flush(idf_c), .ex_mem_flush(emf_c), .md_busy(busy_c),
        .stall_cycles(cnt_c));

    hazard_ctrl #(.REG_ADDR_W(5), .MD_LATENCY(2), .BRANCH_IN_EX(1), .CNT_W(16)) dut_d (
        .clk(clk), .rst(rst), .jump(jump), .pc_src(pc_src), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rt(id_uses_rt), .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .md_start(md_start),
        .cnt_clr(cnt_clr), .pc_write(pw_d), .if_id_write(ifw_d), .id_ex_write(idw_d),
        .if_id_flush(iff_d), .id_ex_flush(idf_d), .ex_mem_flush(emf_d), .md_busy(busy_d),
        .stall_cycles(cnt_d));

    // Inputs change on the falling edge; outputs are sampled 1 ns later.
    task automatic next_cycle();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        rst = 1'b0; jump = 1'b0; pc_src = 1'b0; id_rs = 5'd0; id_rt = 5'd0;
        id_uses_rt = 1'b0; ex_mem_read = 1'b0; ex_rt = 5'd0; md_start = 1'b0; cnt_clr = 1'b0;
    endtask

    task automatic clear_counters();
        idle_inputs();
        cnt_clr = 1'b1;
        next_cycle();
        idle_inputs();
    endtask

    task automatic load_use_rs(input logic [4:0] r);
        ex_mem_read = 1'b1; ex_rt = r; id_rs = r;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1; md_start = 1'b1; load_use_rs(5'd8); jump = 1'b1;
        next_cycle();
        #1;
        checks++;
        if (ctl_a !== C_DEF) begin
            failures++; $display("FAIL reset_outputs: got %b want %b", ctl_a, C_DEF);
        end
        next_cycle();
        idle_inputs();
        #1;
        checks++;
        if (ctl_a !== C_DEF) begin
            failures++; $display("FAIL post_reset_idle: got %b want %b", ctl_a, C_DEF);
        end
        checks++;
        if (cnt_a !== 16'd0) begin
            failures++; $display("FAIL reset_counter: got %0d want 0", cnt_a);
        end
    endtask

    task automatic test_load_use();
        clear_counters();
        load_use_rs(5'd8);
        #1;
        checks++;
        if (ctl_a !== C_LU) begin
            failures++; $display("FAIL load_use_rs: got %b want %b", ctl_a, C_LU);
        end
        next_cycle();
        idle_inputs();
        load_use_rs(5'd0);
        #1;
        checks++;
        if (ctl_a !== C_DEF) begin
            failures++; $display("FAIL load_use_r0: got %b want %b", ctl_a, C_DEF);
        end
        next_cycle();
        idle_inputs();
        ex_mem_read = 1'b1; ex_rt = 5'd9; id_rs = 5'd3; id_rt = 5'd9; id_uses_rt = 1'b1;
        #1;
        checks++;
        if (ctl_a !== C_LU) begin
            failures++; $display("FAIL load_use_rt: got %b want %b", ctl_a, C_LU);
        end
        next_cycle();
        id_uses_rt = 1'b0;
        #1;
        checks++;
        if (ctl_a !== C_DEF) begin
            failures++; $display("FAIL load_use_rt_unused: got %b want %b", ctl_a, C_DEF);
        end
        next_cycle();
        idle_inputs();
        ex_mem_read = 1'b0; ex_rt = 5'd8; id_rs = 5'd8;
        #1;
        checks++;
        if (ctl_a !== C_DEF) begin
            failures++; $display("FAIL no_load_no_stall: got %b want %b", ctl_a, C_DEF);
        end
        next_cycle();
        idle_inputs();
        #1;
        checks++;
        if (cnt_a !== 16'd2) begin
            failures++; $display("FAIL load_use_count: got %0d want 2", cnt_a);
        end
    endtask

    task automatic test_md_sequence();
        logic [6:0] exp_seq [3];
        exp_seq[0] = C_MD; exp_seq[1] = C_MDB; exp_seq[2] = C_MDB;
        clear_counters();
        for (int i = 0; i < 3; i++) begin
            md_start = 1'b1;
            #1;
            checks++;
            if (ctl_a !== exp_seq[i]) begin
                failures++; $display("FAIL md_cycle%0d: got %b want %b", i, ctl_a, exp_seq[i]);
            end
            next_cycle();
        end
        md_start = 1'b0;
        #1;
        checks++;
        if (ctl_a !== C_DEF) begin
            failures++; $display("FAIL md_release: got %b want %b", ctl_a, C_DEF);
        end
        checks++;
        if (cnt_a !== 16'd3) begin
            failures++; $display("FAIL md_count: got %0d want 3", cnt_a);
        end
    endtask

    task automatic test_md_latency2();
        clear_counters();
        md_start = 1'b1;
        #1;
        checks++;
        if (ctl_d !== C_MD) begin
            failures++; $display("FAIL lat2_stall: got %b want %b", ctl_d, C_MD);
        end
        next_cycle();
        md_start = 1'b0;
        #1;
        checks++;
        if (ctl_d !== C_DEF) begin
            failures++; $display("FAIL lat2_release: got %b want %b", ctl_d, C_DEF);
        end
        checks++;
        if (cnt_d !== 16'd1) begin
            failures++; $display("FAIL lat2_count: got %0d want 1", cnt_d);
        end
        // let the latency-4 instances finish their sequence
        next_cycle();
        next_cycle();
        next_cycle();
    endtask

    task automatic test_load_use_masked();
        clear_counters();
        md_start = 1'b1;
        next_cycle();
        load_use_rs(5'd7);
        #1;
        checks++;
        if (ctl_a !== C_MDB) begin
            failures++; $display("FAIL lu_masked_busy: got %b want %b", ctl_a, C_MDB);
        end
        next_cycle();
        next_cycle();
        md_start = 1'b0;
        #1;
        checks++;
        if (ctl_a !== C_LU) begin
            failures++; $display("FAIL lu_redetect: got %b want %b", ctl_a, C_LU);
        end
        next_cycle();
        idle_inputs();
        #1;
        checks++;
        if (cnt_a !== 16'd4) begin
            failures++; $display("FAIL lu_masked_count: got %0d want 4", cnt_a);
        end
    endtask

    task automatic test_branch_abort();
        idle_inputs();
        md_start = 1'b1;
        next_cycle();
        next_cycle();
        pc_src = 1'b1;
        #1;
        checks++;
        if (ctl_a !== (C_BR_EX | 7'b0000001)) begin
            failures++; $display("FAIL abort_flush: got %b want %b", ctl_a, C_BR_EX | 7'b0000001);
        end
        checks++;
        if (ctl_b !== (C_BR_MEM | 7'b0000001)) begin
            failures++; $display("FAIL abort_flush_mem: got %b want %b", ctl_b, C_BR_MEM | 7'b0000001);
        end
        next_cycle();
        idle_inputs();
        #1;
        checks++;
        if (ctl_a !== C_DEF) begin
            failures++; $display("FAIL abort_idle: got %b want %b", ctl_a, C_DEF);
        end
        // md_start alongside pc_src must not start a sequence
        pc_src = 1'b1; md_start = 1'b1;
        next_cycle();
        idle_inputs();
        #1;
        checks++;
        if (ctl_a !== C_DEF) begin
            failures++; $display("FAIL md_ignored_on_branch: got %b want %b", ctl_a, C_DEF);
        end
    endtask

    task automatic test_jump_priority();
        idle_inputs();
        jump = 1'b1; load_use_rs(5'd12);
        #1;
        checks++;
        if (ctl_a !== C_LU) begin
            failures++; $display("FAIL jump_masked: got %b want %b", ctl_a, C_LU);
        end
        next_cycle();
        ex_mem_read = 1'b0;
        #1;
        checks++;
        if (ctl_a !== C_JMP) begin
            failures++; $display("FAIL jump_retry: got %b want %b", ctl_a, C_JMP);
        end
        next_cycle();
        idle_inputs();
        pc_src = 1'b1; jump = 1'b1; load_use_rs(5'd12);
        #1;
        checks++;
        if (ctl_a !== C_BR_EX) begin
            failures++; $display("FAIL branch_over_lu: got %b want %b", ctl_a, C_BR_EX);
        end
        next_cycle();
        idle_inputs();
    endtask

    task automatic test_branch_stage();
        idle_inputs();
        pc_src = 1'b1;
        #1;
        checks++;
        if (ctl_a !== C_BR_EX) begin
            failures++; $display("FAIL branch_ex: got %b want %b", ctl_a, C_BR_EX);
        end
        checks++;
        if (ctl_b !== C_BR_MEM) begin
            failures++; $display("FAIL branch_mem: got %b want %b", ctl_b, C_BR_MEM);
        end
        next_cycle();
        idle_inputs();
    endtask

    task automatic test_saturate();
        clear_counters();
        for (int i = 0; i < 20; i++) begin
            load_use_rs(5'(i % 31 + 1));
            next_cycle();
        end
        idle_inputs();
        #1;
        checks++;
        if (cnt_c !== 4'd15) begin
            failures++; $display("FAIL saturate_4bit: got %0d want 15", cnt_c);
        end
        checks++;
        if (cnt_a !== 16'd20) begin
            failures++; $display("FAIL count_16bit: got %0d want 20", cnt_a);
        end
        cnt_clr = 1'b1; load_use_rs(5'd5);
        next_cycle();
        idle_inputs();
        #1;
        checks++;
        if (cnt_c !== 4'd0) begin
            failures++; $display("FAIL clr_priority: got %0d want 0", cnt_c);
        end
    endtask

    task automatic test_reset_mid_busy();
        idle_inputs();
        load_use_rs(5'd4);
        next_cycle();
        idle_inputs();
        md_start = 1'b1;
        next_cycle();
        #1;
        checks++;
        if (ctl_a !== C_MDB) begin
            failures++; $display("FAIL busy_before_rst: got %b want %b", ctl_a, C_MDB);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (ctl_a !== C_DEF) begin
            failures++; $display("FAIL rst_in_busy: got %b want %b", ctl_a, C_DEF);
        end
        next_cycle();
        idle_inputs();
        #1;
        checks++;
        if (ctl_a !== C_DEF) begin
            failures++; $display("FAIL after_rst_busy: got %b want %b", ctl_a, C_DEF);
        end
        checks++;
        if (cnt_a !== 16'd0) begin
            failures++; $display("FAIL after_rst_count: got %0d want 0", cnt_a);
        end
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        next_cycle();
        test_reset();
        test_load_use();
        test_md_sequence();
        test_md_latency2();
        test_load_use_masked();
        test_branch_abort();
        test_jump_priority();
        test_branch_stage();
        test_saturate();
        test_reset_mid_busy();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
